// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   size_e  - access size encoding carried on reqSize
//   state_e - control FSM states
//   req_t   - request fields captured at acceptance
package lsu_pkg;

  localparam int LSU_MEM_WORDS = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXEC  = 2'b01,
    MERGE = 2'b10,
    RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane
// merge for sub-word stores. Purely combinational.
//   size  - access size
//   sgn   - sign-extend the extracted lane
//   off   - byte offset within the word (addr[1:0])
//   rdata - word read from memory (load source)
//   mword - word captured for read-modify-write (merge base)
//   wdata - right-aligned store data
//   ldata - extended load result
//   mdata - merge base with the addressed lane replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] mword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = rdata[{off, 3'b000} +: 8];
    h     = off[1] ? rdata[31:16] : rdata[15:0];
    ldata = '0;
    mdata = mword;
    case (size)
      SIZE_BYTE: begin
        ldata = {{24{sgn & b[7]}}, b};
        mdata[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        ldata = {{16{sgn & h[15]}}, h};
        mdata[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_WORD: begin
        ldata = rdata;
        mdata = wdata;
      end
      default: begin
        ldata = '0;
        mdata = mword;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit in front of a
// word-addressed data memory with combinational read.
//   clk, rstN                      - clock, async active-low reset
//   reqValid/reqReady + req fields - core request (accepted only in IDLE)
//   rspValid/rspReady, rspData,
//   rspFault                       - response, held until handshake
//   memWriteEnable, memAdress,
//   memWriteData, memReadData      - data memory port (word index address)
// Sub-word stores are read-modify-write: EXEC reads the word into a
// merge register, MERGE writes it back with the lane replaced.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspFault,
  output logic        memWriteEnable,
  output logic [31:0] memAdress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  state_e      state_q, state_d;
  req_t        rq;
  logic [31:0] merge_q;
  logic [31:0] ldata, mdata;
  logic [31:0] widx;
  logic        fault;

  assign widx = {2'b00, rq.addr[31:2]};

  always_comb begin
    fault = 1'b0;
    case (rq.size)
      SIZE_HALF: fault = rq.addr[0];
      SIZE_WORD: fault = (rq.addr[1:0] != 2'b00);
      SIZE_RSVD: fault = 1'b1;
      default:   fault = 1'b0;
    endcase
    if (widx >= 32'(MEM_WORDS)) fault = 1'b1;
  end

  lsu_lane_align u_align (
    .size  (rq.size),
    .sgn   (rq.sgn),
    .off   (rq.addr[1:0]),
    .rdata (memReadData),
    .mword (merge_q),
    .wdata (rq.wdata),
    .ldata (ldata),
    .mdata (mdata)
  );

  assign reqReady = (state_q == IDLE);
  assign rspValid = (state_q == RESP);

  always_comb begin
    state_d        = state_q;
    memWriteEnable = 1'b0;
    memWriteData   = '0;
    memAdress      = '0;
    case (state_q)
      IDLE: if (reqValid) state_d = EXEC;
      EXEC: begin
        memAdress = widx;
        if (fault || !rq.write) begin
          state_d = RESP;
        end else if (rq.size == SIZE_WORD) begin
          memWriteEnable = 1'b1;
          memWriteData   = rq.wdata;
          state_d        = RESP;
        end else begin
          state_d = MERGE;
        end
      end
      MERGE: begin
        memAdress      = widx;
        memWriteEnable = 1'b1;
        memWriteData   = mdata;
        state_d        = RESP;
      end
      RESP: if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      rq       <= '0;
      merge_q  <= '0;
      rspData  <= '0;
      rspFault <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && reqValid) begin
        rq.write <= reqWrite;
        rq.size  <= size_e'(reqSize);
        rq.sgn   <= reqSigned;
        rq.addr  <= reqAddr;
        rq.wdata <= reqWdata;
      end
      if (state_q == EXEC) begin
        rspFault <= fault;
        rspData  <= (fault || rq.write) ? 32'h0 : ldata;
        if (!fault && rq.write && rq.size != SIZE_WORD) merge_q <= memReadData;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-003 rstN  in  1  asynchronous active-low reset.
REQ-004 reqValid  in  1  core request valid; reqReady  out  1  unit can accept a request.
REQ-005 reqWrite  in  1  1=store, 0=load; reqSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-006 reqSigned  in  1  sign-extend loads; reqAddr  in  32  byte address; reqWdata  in  32  store data, right-aligned.
REQ-007 rspValid  out  1  response valid; rspReady  in  1  core accepts response.
REQ-008 rspData  out  32  load result, zero/sign-extended; rspFault  out  1  access rejected.
REQ-009 memWriteEnable  out  1; memAdress  out  32  word index; memWriteData  out  32; memReadData  in  32  combinational read data from data memory.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, MERGE, RESP; reqReady=1 only in IDLE.
REQ-011 IDLE: on reqValid&reqReady, capture write, size, signed, addr, wdata into registers -> EXEC.
REQ-012 memAdress SHALL equal captured addr[31:2] zero-extended, driven in EXEC and MERGE; 0 otherwise.
REQ-013 Fault: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS; EXEC -> RESP with rspFault=1, rspData=0, no memory write.
REQ-014 Load in EXEC: select lane little-endian (byte lane addr[1:0], half lane addr[1]), extend per reqSigned, register into rspData -> RESP.
REQ-015 Word store in EXEC: memWriteEnable=1, memWriteData=wdata -> RESP.
REQ-016 Byte/half store in EXEC: latch memReadData into merge register -> MERGE; MERGE: memWriteEnable=1, memWriteData=merge word with addressed lane replaced by wdata low bits -> RESP.
REQ-017 memWriteEnable SHALL be asserted for exactly one cycle per non-faulting store, never for loads or faults.
REQ-018 RESP: rspValid=1, rspData/rspFault held stable until rspValid&rspReady -> IDLE; stores return rspData=0.
REQ-019 Latency from accepting edge to rspValid: 2 cycles for loads, word stores, faults; 3 cycles for byte/half stores.
REQ-020 No new request SHALL be accepted until the response handshake completes (one outstanding access).
REQ-021 reqValid while not IDLE SHALL be ignored; request fields only sampled at acceptance.

Reset
REQ-022 rstN low SHALL force state IDLE, all captured/merge registers 0, rspData 0, rspFault 0, rspValid 0, memWriteEnable 0, memAdress 0, immediately and asynchronously.
REQ-023 Reset during MERGE SHALL drop the pending write; memory holds the pre-store word.
REQ-024 After rstN deasserts, reqReady=1 and the first request is accepted on the next rising edge with reqValid=1.

Structure
REQ-025 Package lsu_pkg SHALL hold the size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD), FSM state enum, and default MEM_WORDS constant.
REQ-026 Combinational lane extract/extend and lane merge SHALL live in one sub-module, lsu_lane_align; the FSM and registers stay in load_store_unit.

Verification
REQ-027 Memory word 3 = 0x8899AABB; load byte signed addr 0x0D -> rspData 0xFFFFFFAA, rspFault 0, rspValid 2 cycles after accept.
REQ-028 Same memory; load half unsigned addr 0x0E -> rspData 0x00008899; load word addr 0x0C -> 0x8899AABB.
REQ-029 Store byte 0x55 to addr 0x0E on word 0x8899AABB -> single write cycle in MERGE, word 3 = 0x8855AABB, rspValid 3 cycles after accept.
REQ-030 Faults: half at addr 0x01, word at 0x02, size 11, word at 0x100 with MEM_WORDS 64 -> rspFault 1, rspData 0, memWriteEnable never high.
REQ-031 Hold rspReady low 4 cycles while reqValid stays high -> rspValid/rspData stable, reqReady 0, no second access until handshake.
REQ-032 Assert rstN low during MERGE of a halfword store -> memWriteEnable low immediately, target word unchanged, reqReady 1 after release.
